niosii_system_de2_pulse_out: RTL and testbench



---
 rtl/niosii_system_de2_pulse_out.sv | 124 ++++++++++++
 tb/tb_niosii_system_de2_pulse_out.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/niosii_system_de2_pulse_out.sv
// Avalon-MM output port: each channel drives a static level ORed with a hardware-timed one-shot pulse.
// Ports: clk/reset_n; Avalon slave (address, chipselect, write_n, writedata, readdata); out_port; irq.
// Latency: writes take effect at the sampling edge, readdata is registered (1 cycle); no backpressure.
module niosii_system_de2_pulse_out #(
  parameter int OUT_BITS    = 4,
  parameter int CNT_BITS    = 16,
  parameter int WIDTH_RESET = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [2:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic [OUT_BITS-1:0] out_port,
  output logic                irq
);

  localparam logic [CNT_BITS-1:0] CNT_ONE   = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] WIDTH_RST = CNT_BITS'(WIDTH_RESET);

  logic [OUT_BITS-1:0] data_q,   data_d;
  logic [CNT_BITS-1:0] width_q,  width_d;
  logic [OUT_BITS-1:0] mask_q,   mask_d;
  logic [OUT_BITS-1:0] active_q, active_d;
  logic [OUT_BITS-1:0] done_q,   done_d;
  logic [CNT_BITS-1:0] cnt_q [OUT_BITS];
  logic [CNT_BITS-1:0] cnt_d [OUT_BITS];
  logic [31:0]         readdata_q, readdata_d;

  logic                wr_en;
  logic [OUT_BITS-1:0] trig;
  logic [OUT_BITS-1:0] done_set;
  logic [OUT_BITS-1:0] done_clr;
  logic [CNT_BITS-1:0] eff_width;
  logic                unused_wdata;

  assign wr_en     = chipselect & ~write_n;
  assign trig      = (wr_en && address == 3'd2) ? writedata[OUT_BITS-1:0] : '0;
  // A zero width would never terminate a pulse; run it for one cycle instead.
  assign eff_width = (width_q == '0) ? CNT_ONE : width_q;
  // Upper writedata bits have no storage behind them.
  assign unused_wdata = ^writedata;

  always_comb begin
    data_d     = data_q;
    width_d    = width_q;
    mask_d     = mask_q;
    active_d   = active_q;
    cnt_d      = cnt_q;
    done_set   = '0;
    done_clr   = '0;
    readdata_d = '0;

    if (wr_en) begin
      case (address)
        3'd0:    data_d   = writedata[OUT_BITS-1:0];
        3'd1:    width_d  = writedata[CNT_BITS-1:0];
        3'd3:    mask_d   = writedata[OUT_BITS-1:0];
        3'd4:    done_clr = writedata[OUT_BITS-1:0];
        default: ;
      endcase
    end

    for (int i = 0; i < OUT_BITS; i++) begin
      // A trigger always wins over the final count, so a retrigger extends
      // the pulse and the superseded pulse never reports done.
      if (trig[i]) begin
        active_d[i] = 1'b1;
        cnt_d[i]    = eff_width;
      end else if (active_q[i]) begin
        if (cnt_q[i] == CNT_ONE) begin
          active_d[i] = 1'b0;
          done_set[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] - CNT_ONE;
        end
      end
    end

    // A completing pulse beats a simultaneous software clear of the same bit.
    done_d = (done_q & ~done_clr) | done_set;

    case (address)
      3'd0:    readdata_d = 32'(data_q);
      3'd1:    readdata_d = 32'(width_q);
      3'd2:    readdata_d = 32'(active_q);
      3'd3:    readdata_d = 32'(mask_q);
      3'd4:    readdata_d = 32'(done_q);
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q     <= '0;
      width_q    <= WIDTH_RST;
      mask_q     <= '0;
      active_q   <= '0;
      done_q     <= '0;
      readdata_q <= '0;
      for (int i = 0; i < OUT_BITS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      data_q     <= data_d;
      width_q    <= width_d;
      mask_q     <= mask_d;
      active_q   <= active_d;
      done_q     <= done_d;
      readdata_q <= readdata_d;
      for (int i = 0; i < OUT_BITS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Both terms are flops, so the pins never glitch.
  assign out_port = data_q | active_q;
  assign irq      = |(done_q & mask_q);
  assign readdata = readdata_q;

endmodule

// File: tb/tb_niosii_system_de2_pulse_out.sv
module tb_niosii_system_de2_pulse_out;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  out_port;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  niosii_system_de2_pulse_out #(
    .OUT_BITS(4),
    .CNT_BITS(16),
    .WIDTH_RESET(1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .out_port(out_port),
    .irq(irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  logic [31:0] d;
  int          hi_cnt;
  int          lo_cnt;
  int          irq_cnt;
  int          irq_rise;
  int          irq_first;
  logic        irq_prev;
  logic        first_hi;

  initial begin
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    repeat (3) @(negedge clk);
    check("rst_out_port", 32'(out_port), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_readdata", readdata, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Register readback after reset
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), d);
      check($sformatf("rst_rd_addr%0d", a), d, (a == 1) ? 32'h1 : 32'h0);
    end

    // Basic 5-cycle pulse with IRQ
    wr(3'd1, 32'd5);
    wr(3'd3, 32'h1);
    wr(3'd2, 32'h1);
    address = 3'd2;
    hi_cnt  = 0;
    first_hi = out_port[0];
    for (int i = 0; i < 8; i++) begin
      if (out_port[0]) hi_cnt++;
      if (i == 2) check("active_rd", readdata, 32'h1);
      @(negedge clk);
    end
    check("p5_first_cycle", 32'(first_hi), 32'h1);
    check("p5_high_cycles", 32'(hi_cnt), 32'd5);
    check("p5_irq", 32'(irq), 32'h1);
    rd(3'd4, d);
    check("p5_done", d, 32'h1);
    wr(3'd4, 32'h1);
    check("p5_irq_cleared", 32'(irq), 32'h0);

    // Zero width acts as one cycle, masked IRQ stays low
    wr(3'd3, 32'h0);
    wr(3'd1, 32'h0);
    wr(3'd2, 32'h4);
    hi_cnt  = 0;
    irq_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_port[2]) hi_cnt++;
      if (irq) irq_cnt++;
      @(negedge clk);
    end
    check("w0_high_cycles", 32'(hi_cnt), 32'd1);
    check("w0_irq_cycles", 32'(irq_cnt), 32'd0);
    rd(3'd4, d);
    check("w0_done", d, 32'h4);
    wr(3'd4, 32'h4);

    // Retrigger on the 6th pulse cycle extends to 15 cycles, one done
    wr(3'd3, 32'h2);
    wr(3'd1, 32'd10);
    wr(3'd2, 32'h2);
    hi_cnt    = 0;
    irq_rise  = 0;
    irq_first = -1;
    irq_prev  = irq;
    for (int i = 0; i < 25; i++) begin
      if (out_port[1]) hi_cnt++;
      if (irq && !irq_prev) begin
        irq_rise++;
        if (irq_first < 0) irq_first = i;
      end
      irq_prev = irq;
      if (i == 4) begin
        address    = 3'd2;
        writedata  = 32'h2;
        chipselect = 1'b1;
        write_n    = 1'b0;
      end else begin
        chipselect = 1'b0;
        write_n    = 1'b1;
      end
      @(negedge clk);
    end
    check("rt_high_cycles", 32'(hi_cnt), 32'd15);
    check("rt_done_events", 32'(irq_rise), 32'd1);
    check("rt_done_time", 32'(irq_first), 32'd15);
    rd(3'd4, d);
    check("rt_done", d, 32'h2);
    wr(3'd4, 32'h2);
    wr(3'd3, 32'h0);

    // Done-set beats same-cycle W1C
    wr(3'd1, 32'd3);
    wr(3'd2, 32'h1);
    @(negedge clk);
    @(negedge clk);
    wr(3'd4, 32'h1);
    rd(3'd4, d);
    check("w1c_race_done", d, 32'h1);
    wr(3'd4, 32'h1);
    rd(3'd4, d);
    check("w1c_cleared", d, 32'h0);

    // Trigger coinciding with cnt==1 keeps the pulse going
    wr(3'd2, 32'h2);
    @(negedge clk);
    @(negedge clk);
    wr(3'd2, 32'h2);
    check("tc1_still_high", 32'(out_port[1]), 32'h1);
    rd(3'd4, d);
    check("tc1_no_done", d, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("tc1_ended", 32'(out_port[1]), 32'h0);
    rd(3'd4, d);
    check("tc1_done", d, 32'h2);
    wr(3'd4, 32'h2);

    // Static level ORed with pulse
    wr(3'd0, 32'h8);
    wr(3'd2, 32'h8);
    lo_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (!out_port[3]) lo_cnt++;
      @(negedge clk);
    end
    check("lvl_low_cycles", 32'(lo_cnt), 32'd0);
    rd(3'd4, d);
    check("lvl_done", d, 32'h8);
    wr(3'd0, 32'h0);
    check("lvl_released", 32'(out_port), 32'h0);
    wr(3'd4, 32'h8);

    // Asynchronous reset mid-pulse
    wr(3'd1, 32'd10);
    wr(3'd2, 32'h2);
    @(negedge clk);
    check("ar_pulse_high", 32'(out_port), 32'h2);
    #2 reset_n = 1'b0;
    #1 check("ar_out_drop", 32'(out_port), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    rd(3'd4, d);
    check("ar_done", d, 32'h0);
    rd(3'd1, d);
    check("ar_width", d, 32'h1);
    check("ar_irq", 32'(irq), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
